dmem_ctrl: RTL
==============

DMEM_CTRL -- requirements
Module: dmem_ctrl

Interface
REQ-001 No parameters; all data/address widths SHALL be CPU_WIDTH (32) from rvseed_defines.v.
REQ-002 The block SHALL use one clock; reset SHALL be asynchronous and active-high.
REQ-003 clk  in  1  single clock, all state on rising edge.
REQ-004 rst  in  1  asynchronous active-high reset.
REQ-005 mN_req_valid  in  1  requester N (N=0,1) request present.
REQ-006 mN_req_ready  out  1  request accepted when valid&ready.
REQ-007 mN_req_wen  in  1  1=store, 0=load.
REQ-008 mN_req_addr  in  32  byte address.
REQ-009 mN_req_wdata  in  32  store data, right-aligned (byte in [7:0], half in [15:0]).
REQ-010 mN_req_size  in  2  0=byte, 1=half, 2=word, 3=reserved (treated as error).
REQ-011 mN_req_uns  in  1  load zero-extend when 1, sign-extend when 0.
REQ-012 mN_rsp_valid  out  1  one-cycle response pulse.
REQ-013 mN_rsp_rdata  out  32  load data, extended; 0 for stores and errors.
REQ-014 mN_rsp_err  out  1  misaligned or reserved size; valid with rsp_valid.
REQ-015 mem_wen, mem_ren  out  1 each  data memory write/read enables.
REQ-016 mem_addr  out  32  word-aligned address (bits [1:0] = 0).
REQ-017 mem_wdata  out  32  full-word write data.
REQ-018 mem_rdata  in  32  combinational read data (valid same cycle as mem_ren).

Function
REQ-019 FSM states SHALL be IDLE, ACCESS, WRITE, RESP.
REQ-020 In IDLE, mN_req_ready SHALL be 1 only for the granted requester; the other SHALL be 0; all ready=0 outside IDLE.
REQ-021 Arbitration: sole valid requester is granted; both valid → requester not granted last; pointer updates only on accept.
REQ-022 On accept, addr/wdata/size/wen/uns/requester id SHALL be latched; next state ACCESS.
REQ-023 Misaligned (half with addr[0]=1, word with addr[1:0]≠0) or size=3: IDLE→RESP directly, no mem_ren/mem_wen, err=1.
REQ-024 ACCESS: mem_ren=1, mem_addr={addr[31:2],2'b00}.
REQ-025 ACCESS, load: select byte lane addr[1:0] / half lane addr[1], extend per uns, register result; → RESP.
REQ-026 ACCESS, word store: mem_wen=1, mem_wdata=wdata; → RESP.
REQ-027 ACCESS, byte/half store: register merged word (mem_rdata with addressed lane replaced); → WRITE.
REQ-028 WRITE: mem_wen=1 with merged word, same mem_addr; → RESP.
REQ-029 RESP: rsp_valid=1 for exactly one cycle to the latched requester only; → IDLE.
REQ-030 Latency from accept edge: load/word store rsp at +2 cycles; sub-word store +3; error +1.
REQ-031 mem_wen and mem_ren SHALL be 0 in IDLE and RESP; mem_addr/mem_wdata don't-care when enables are 0 but SHALL be driven from latched registers.
REQ-032 Requests arriving in non-IDLE states SHALL be held off (ready=0); requester must hold valid and fields stable until accepted.

Reset
REQ-033 Reset SHALL force IDLE, last-grant pointer=1 (requester 0 wins first tie), all rsp_valid/err/rdata=0, mem_wen=mem_ren=0.
REQ-034 Reset mid-transaction SHALL abort it with no response and no further memory write; a WRITE in progress at reset assertion SHALL not complete.

Structure
REQ-035 State encoding and size codes (BYTE/HALF/WORD) SHALL live in rvseed_defines.v.
REQ-036 One sub-module dmem_rr_arb (2-way round-robin grant) is natural; lane extract/merge stays inline.

Verification
REQ-037 Word store m0 addr 0x10 data 0xDEADBEEF, then load word → rdata 0xDEADBEEF, rsp at accept+2, err=0.
REQ-038 Byte store 0xA5 addr 0x11 over 0xDEADBEEF → memory 0xDEADA5EF; signed byte load 0x11 → 0xFFFFFFA5, unsigned → 0x000000A5.
REQ-039 Half load addr 0x13 → err=1, rsp at accept+1, no mem_ren, rdata 0.
REQ-040 m0 and m1 valid continuously for 4 transactions → grants m0,m1,m0,m1; each rsp only to its requester.
REQ-041 rst asserted during WRITE of byte store → memory word unchanged, no rsp_valid, state IDLE after release.

Source files
------------

// File: rtl/dmem_ctrl_pkg.sv
// Shared types and constants for the two-requester data-memory controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package dmem_ctrl_pkg;

    localparam int CPU_WIDTH = 32;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_WRITE  = 2'd2,
        ST_RESP   = 2'd3
    } state_t;

    localparam logic [1:0] SIZE_BYTE = 2'd0;
    localparam logic [1:0] SIZE_HALF = 2'd1;
    localparam logic [1:0] SIZE_WORD = 2'd2;

    typedef struct packed {
        logic                 wen;
        logic [CPU_WIDTH-1:0] addr;
        logic [CPU_WIDTH-1:0] wdata;
        logic [1:0]           size;
        logic                 uns;
    } req_t;

    // True when the access can never be issued: reserved size or a
    // half/word that is not naturally aligned.
    function automatic logic req_bad(input logic [1:0] size, input logic [1:0] lsb);
        case (size)
            SIZE_BYTE: return 1'b0;
            SIZE_HALF: return lsb[0];
            SIZE_WORD: return lsb != 2'b00;
            default:   return 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/dmem_ctrl_if.sv
// Requester and memory-side signal bundle for dmem_ctrl.
// Latency: n/a (wiring only).
// Backpressure: mN_req_ready holds requests off; responses cannot be stalled.
// master = requesters plus memory model, slave = the controller.
interface dmem_ctrl_if;
    import dmem_ctrl_pkg::*;

    logic                 m0_req_valid, m0_req_ready, m0_req_wen, m0_req_uns;
    logic [CPU_WIDTH-1:0] m0_req_addr, m0_req_wdata;
    logic [1:0]           m0_req_size;
    logic                 m0_rsp_valid, m0_rsp_err;
    logic [CPU_WIDTH-1:0] m0_rsp_rdata;

    logic                 m1_req_valid, m1_req_ready, m1_req_wen, m1_req_uns;
    logic [CPU_WIDTH-1:0] m1_req_addr, m1_req_wdata;
    logic [1:0]           m1_req_size;
    logic                 m1_rsp_valid, m1_rsp_err;
    logic [CPU_WIDTH-1:0] m1_rsp_rdata;

    logic                 mem_wen, mem_ren;
    logic [CPU_WIDTH-1:0] mem_addr, mem_wdata, mem_rdata;

    modport master (
        output m0_req_valid, m0_req_wen, m0_req_uns, m0_req_addr, m0_req_wdata, m0_req_size,
        output m1_req_valid, m1_req_wen, m1_req_uns, m1_req_addr, m1_req_wdata, m1_req_size,
        input  m0_req_ready, m0_rsp_valid, m0_rsp_err, m0_rsp_rdata,
        input  m1_req_ready, m1_rsp_valid, m1_rsp_err, m1_rsp_rdata,
        input  mem_wen, mem_ren, mem_addr, mem_wdata,
        output mem_rdata
    );

    modport slave (
        input  m0_req_valid, m0_req_wen, m0_req_uns, m0_req_addr, m0_req_wdata, m0_req_size,
        input  m1_req_valid, m1_req_wen, m1_req_uns, m1_req_addr, m1_req_wdata, m1_req_size,
        output m0_req_ready, m0_rsp_valid, m0_rsp_err, m0_rsp_rdata,
        output m1_req_ready, m1_rsp_valid, m1_rsp_err, m1_rsp_rdata,
        output mem_wen, mem_ren, mem_addr, mem_wdata,
        input  mem_rdata
    );

endinterface

// File: rtl/dmem_rr_arb.sv
// Two-way round-robin grant; on a tie the requester not granted last wins.
// Latency: combinational grant; pointer updates on the accept edge only.
// Backpressure: none of its own; accept gates the pointer update.
// Ports: req[1:0] in, accept in, gnt_vld/gnt_id out.
module dmem_rr_arb (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       accept,
    output logic       gnt_vld,
    output logic       gnt_id
);

    logic last;

    always_comb begin
        gnt_vld = |req;
        gnt_id  = 1'b0;
        if (req == 2'b11) begin
            gnt_id = ~last;
        end else if (req[1]) begin
            gnt_id = 1'b1;
        end
    end

    // Reset to 1 so requester 0 wins the first tie.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last <= 1'b1;
        end else if (accept) begin
            last <= gnt_id;
        end
    end

endmodule

// File: rtl/dmem_ctrl.sv
// Data-memory controller: two requesters share one word-wide memory port.
// Latency from accept: load / word store 2 cycles, byte/half store 3, bad access 1.
// Backpressure: ready only in IDLE for the granted requester; responses are single-cycle pulses.
// Ports: clk, rst (async, active-high), bus (dmem_ctrl_if.slave) carrying both requesters and the memory.
module dmem_ctrl
    import dmem_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    dmem_ctrl_if.slave  bus
);

    state_t               state, state_nxt;
    req_t                 r_req, in_req;
    logic                 r_id, r_err;
    logic [CPU_WIDTH-1:0] r_data;
    logic                 gnt_vld, gnt_id, accept, in_bad;
    logic [7:0]           ld_byte;
    logic [15:0]          ld_half;
    logic [CPU_WIDTH-1:0] ld_val, merged;

    dmem_rr_arb u_arb (
        .clk     (clk),
        .rst     (rst),
        .req     ({bus.m1_req_valid, bus.m0_req_valid}),
        .accept  (accept),
        .gnt_vld (gnt_vld),
        .gnt_id  (gnt_id)
    );

    assign accept = (state == ST_IDLE) && gnt_vld;

    always_comb begin
        if (gnt_id) begin
            in_req = {bus.m1_req_wen, bus.m1_req_addr, bus.m1_req_wdata, bus.m1_req_size, bus.m1_req_uns};
        end else begin
            in_req = {bus.m0_req_wen, bus.m0_req_addr, bus.m0_req_wdata, bus.m0_req_size, bus.m0_req_uns};
        end
        in_bad = req_bad(in_req.size, in_req.addr[1:0]);
    end

    // Lane extract for loads and read-modify-write merge for sub-word stores.
    always_comb begin
        ld_byte = bus.mem_rdata[{r_req.addr[1:0], 3'b000} +: 8];
        ld_half = r_req.addr[1] ? bus.mem_rdata[31:16] : bus.mem_rdata[15:0];
        case (r_req.size)
            SIZE_BYTE: ld_val = r_req.uns ? {24'd0, ld_byte} : {{24{ld_byte[7]}}, ld_byte};
            SIZE_HALF: ld_val = r_req.uns ? {16'd0, ld_half} : {{16{ld_half[15]}}, ld_half};
            default:   ld_val = bus.mem_rdata;
        endcase
        merged = bus.mem_rdata;
        if (r_req.size == SIZE_BYTE) begin
            merged[{r_req.addr[1:0], 3'b000} +: 8] = r_req.wdata[7:0];
        end else begin
            merged[{r_req.addr[1], 4'b0000} +: 16] = r_req.wdata[15:0];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt        = state;
        bus.m0_req_ready = 1'b0;
        bus.m1_req_ready = 1'b0;
        bus.mem_ren      = 1'b0;
        bus.mem_wen      = 1'b0;
        bus.mem_addr     = {r_req.addr[31:2], 2'b00};
        bus.mem_wdata    = (state == ST_WRITE) ? r_data : r_req.wdata;
        bus.m0_rsp_valid = (state == ST_RESP) && !r_id;
        bus.m1_rsp_valid = (state == ST_RESP) && r_id;
        unique case (state)
            ST_IDLE: begin
                bus.m0_req_ready = gnt_vld && !gnt_id;
                bus.m1_req_ready = gnt_vld && gnt_id;
                if (accept) begin
                    state_nxt = in_bad ? ST_RESP : ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                bus.mem_ren = 1'b1;
                bus.mem_wen = r_req.wen && (r_req.size == SIZE_WORD);
                state_nxt   = (r_req.wen && r_req.size != SIZE_WORD) ? ST_WRITE : ST_RESP;
            end
            ST_WRITE: begin
                bus.mem_wen = 1'b1;
                state_nxt   = ST_RESP;
            end
            ST_RESP: begin
                state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
        // Stores and rejected accesses return zero data.
        bus.m0_rsp_rdata = (bus.m0_rsp_valid && !r_req.wen && !r_err) ? r_data : '0;
        bus.m1_rsp_rdata = (bus.m1_rsp_valid && !r_req.wen && !r_err) ? r_data : '0;
        bus.m0_rsp_err   = bus.m0_rsp_valid && r_err;
        bus.m1_rsp_err   = bus.m1_rsp_valid && r_err;
    end

    // r_data holds the extended load result or, for stores, the merged word.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_req  <= '0;
            r_id   <= 1'b0;
            r_err  <= 1'b0;
            r_data <= '0;
        end else begin
            if (accept) begin
                r_req <= in_req;
                r_id  <= gnt_id;
                r_err <= in_bad;
            end
            if (state == ST_ACCESS) begin
                r_data <= r_req.wen ? merged : ld_val;
            end
        end
    end

endmodule
